// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider: one quotient bit per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN to add the signed_mode input (two's complement operands).
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   prem_q, prem_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
`endif

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     shifted;
  logic               trial_ok;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   q_next;

  always_comb begin
`ifdef SIGNED_DIV_EN
    mag_a = (signed_mode && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    mag_b = (signed_mode && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
`else
    mag_a = dividend;
    mag_b = divisor;
`endif
  end

  // partial_rem < divisor, so a non-negative trial always fits back into WIDTH bits
  always_comb begin
    shifted  = {prem_q, shift_q[WIDTH-1]};
    trial_ok = (shifted >= {1'b0, dvs_q});
    trial    = shifted[WIDTH-1:0] - dvs_q;
    q_next   = {shift_q[WIDTH-2:0], trial_ok};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shift_d = shift_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH);
            prem_d  = '0;
            shift_d = mag_a;
            dvs_d   = mag_b;
`ifdef SIGNED_DIV_EN
            negq_d  = signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negr_d  = signed_mode && dividend[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        prem_d  = trial_ok ? trial : shifted[WIDTH-1:0];
        shift_d = q_next;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
          // signs applied on entry to DONE so signed mode costs no extra cycle
          quot_d  = negq_q ? (~q_next + 1'b1) : q_next;
          rem_d   = negr_q ? (~prem_d + 1'b1) : prem_d;
`else
          quot_d  = q_next;
          rem_d   = prem_d;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shift_q <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shift_q <= shift_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8); signed cases are built when SIGNED_DIV_EN is defined.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
`ifdef SIGNED_DIV_EN
  logic       signed_mode;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SIGNED_DIV_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_unsigned(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'd0; e.r = 8'd0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 9;
    end
    sb.push_back(e);
  endtask

  task automatic push_signed(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia;
    int   ib;
    int   iq;
    int   ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin
      e.q = 8'd0; e.r = 8'd0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      e.q = iq[7:0]; e.r = ir[7:0]; e.dbz = 1'b0; e.lat = 9;
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SIGNED_DIV_EN
    signed_mode = sm;
`else
    if (sm) $display("note: signed request issued to unsigned build");
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_n, output bit seen);
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int unsigned i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        lat  = int'(i);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
`ifdef SIGNED_DIV_EN
    signed_mode = 1'b0;
`endif
    #12;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat; int bn; bit seen; exp_t e;
    push_unsigned(8'd200, 8'd7);
    issue(8'd200, 8'd7, 1'b0);
    wait_done(lat, bn, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL basic_timeout: no done, required done"); end
    vectors++;
    if (lat !== e.lat) begin miscompares++; $display("FAIL basic_latency: got %0d required %0d", lat, e.lat); end
    vectors++;
    if (bn !== 8) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d required 8", bn); end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      miscompares++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got done=%b required 0", done); end
  endtask

  task automatic test_div_zero;
    int lat; int bn; bit seen; exp_t e;
    push_unsigned(8'd5, 8'd0);
    issue(8'd5, 8'd0, 1'b0);
    wait_done(lat, bn, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || lat !== e.lat) begin miscompares++; $display("FAIL zero_latency: got %0d required %0d", lat, e.lat); end
    vectors++;
    if (bn !== 0) begin miscompares++; $display("FAIL zero_busy: got %0d busy cycles required 0", bn); end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      miscompares++;
      $display("FAIL zero_result: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_back_to_back;
    int lat; int bn; bit seen; exp_t e;
    push_unsigned(8'd3, 8'd10);
    issue(8'd3, 8'd10, 1'b0);
    wait_done(lat, bn, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      miscompares++;
      $display("FAIL small_result: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    // held high through DONE: that edge must be ignored, the IDLE edge accepts
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    push_unsigned(8'd255, 8'd1);
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL b2b_idle: got busy=%b done=%b required 0 0", busy, done); end
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    wait_done(lat, bn, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || lat !== e.lat) begin miscompares++; $display("FAIL b2b_latency: got %0d required %0d", lat, e.lat); end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      miscompares++;
      $display("FAIL b2b_result: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_ignore_start;
    int lat; bit seen; exp_t e;
    push_unsigned(8'd100, 8'd9);
    issue(8'd100, 8'd9, 1'b0);
    lat = 0; seen = 1'b0;
    for (int unsigned i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; lat = int'(i); end
      if (i == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
      if (i == 4) start = 1'b0;
    end
    e = sb.pop_front();
    vectors++;
    if (!seen || lat !== e.lat) begin miscompares++; $display("FAIL ignore_latency: got %0d required %0d", lat, e.lat); end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      miscompares++;
      $display("FAIL ignore_result: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder} !== {2'b00, e.q, e.r}) begin
      miscompares++;
      $display("FAIL hold_result: got busy=%b done=%b q=%0d r=%0d required 0 0 q=%0d r=%0d",
               busy, done, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_abort;
    int lat; int bn; bit seen; exp_t e;
    issue(8'd77, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dbz=%b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(lat, bn, seen);
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_no_done: got done after %0d cycles required none", lat); end
    push_unsigned(8'd17, 8'd4);
    issue(8'd17, 8'd4, 1'b0);
    wait_done(lat, bn, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      miscompares++;
      $display("FAIL after_abort_result: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_signed;
    int lat; int bn; bit seen; exp_t e;
    logic [7:0] sa[4];
    logic [7:0] sbv[4];
    sa[0] = 8'hF9; sbv[0] = 8'h02;
    sa[1] = 8'h80; sbv[1] = 8'hFF;
    sa[2] = 8'h64; sbv[2] = 8'hF9;
    sa[3] = 8'hE3; sbv[3] = 8'h00;
    for (int unsigned k = 0; k < 4; k++) begin
      push_signed(sa[k], sbv[k]);
      issue(sa[k], sbv[k], 1'b1);
      wait_done(lat, bn, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen || lat !== e.lat || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        miscompares++;
        $display("FAIL signed_%0d: got lat=%0d q=%h r=%h dbz=%b required lat=%0d q=%h r=%h dbz=%b",
                 k, lat, quotient, remainder, div_by_zero, e.lat, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_random;
    int lat; int bn; bit seen; exp_t e;
    logic [7:0] a;
    logic [7:0] b;
    for (int unsigned k = 0; k < 20; k++) begin
      a = 8'($urandom);
      b = (k == 0) ? 8'd255 : 8'($urandom_range(1, 255));
      push_unsigned(a, b);
      issue(a, b, 1'b0);
      wait_done(lat, bn, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen || lat !== e.lat || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        miscompares++;
        $display("FAIL random_%0d: %0d/%0d got lat=%0d q=%0d r=%0d required lat=%0d q=%0d r=%0d",
                 k, a, b, lat, quotient, remainder, e.lat, e.q, e.r);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_abort();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    test_random();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
